// File: rtl/conv_pkg.sv
// conv_window_mac shared types, default sizes and helpers.
// Index order for windows and weights is (channel, row, col).
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam int K_DEF  = 3;
  localparam int CH_DEF = 3;
  localparam int DW_DEF = 8;
  localparam int WW_DEF = 8;

  localparam int WIN_ELEMS  = K_DEF * K_DEF * CH_DEF;
  localparam int PROD_WIDTH = DW_DEF + WW_DEF + 1;

  function automatic int idx(
    input int k,
    input int m,
    input int n,
    input int kk
  );
    return k * kk * kk + m * kk + n;
  endfunction

  // Clamp to unsigned [0, 2^dw-1] or signed dw-bit range.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 dw,
    input bit                 relu
  );
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    if (relu) begin
      lo = 64'sd0;
      hi = (64'sd1 <<< dw) - 64'sd1;
    end else begin
      lo = -(64'sd1 <<< (dw - 1));
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    end
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_window_mac_dot.sv
// Combinational KxK signed dot product of one channel slice.
// Pixels are unsigned, weights signed; result sign-extended.
module conv_dot_kxk #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int KK           = 9,
  parameter int ACC_WIDTH    = 24
) (
  input  logic [KK*DATA_WIDTH-1:0]   pix,
  input  logic [KK*WEIGHT_WIDTH-1:0] wts,
  output logic signed [ACC_WIDTH-1:0] sum
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH + 1;

  logic signed [PW-1:0] prod [KK];

  always_comb begin
    for (int i = 0; i < KK; i++) begin
      prod[i] = $signed({1'b0, pix[i*DATA_WIDTH +: DATA_WIDTH]})
              * $signed(wts[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < KK; i++) begin
      sum = sum + ACC_WIDTH'(prod[i]);
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// Single-filter window MAC: one channel per cycle, shift, saturate.
// Define CONV_WINDOW_MAC_RELU_EN for ReLU (unsigned) output clamping.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = DW_DEF,
  parameter int CHANNELS     = CH_DEF,
  parameter int KERNEL_SIZE  = K_DEF,
  parameter int WEIGHT_WIDTH = WW_DEF,
  parameter int BIAS_WIDTH   = 16,
  parameter int ACC_WIDTH    = 24,
  parameter int OUT_SHIFT    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic window_valid,
  input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE*CHANNELS-1:0]
               window_data,
  output logic window_ready,
  input  logic cfg_wt_wr_en,
  input  logic [7:0] cfg_wt_addr,
  input  logic [WEIGHT_WIDTH-1:0] cfg_wt_data,
  input  logic cfg_bias_wr_en,
  input  logic [BIAS_WIDTH-1:0] cfg_bias_data,
  output logic cfg_ready,
  output logic out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic out_ready
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ELEMS = KK * CHANNELS;
  localparam int WINW  = DATA_WIDTH * ELEMS;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AIW   = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int MINACC =
    DATA_WIDTH + WEIGHT_WIDTH + 1 + $clog2(ELEMS);

`ifdef CONV_WINDOW_MAC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  if (ACC_WIDTH < MINACC || ACC_WIDTH < BIAS_WIDTH) begin : g_acc_chk
    $error("conv_window_mac: ACC_WIDTH too small");
  end

  state_t state;
  state_t state_nx;

  logic [WINW-1:0]                win_q;
  logic signed [WEIGHT_WIDTH-1:0] wt_q [ELEMS];
  logic signed [BIAS_WIDTH-1:0]   bias_q;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_nx;
  logic signed [ACC_WIDTH-1:0]    dot;
  logic [CW-1:0]                  ch_q;
  logic                           last_ch;
  logic                           wt_ok;

  logic                           pend_v;
  logic [AIW-1:0]                 pend_addr;
  logic [WEIGHT_WIDTH-1:0]        pend_data;

  logic [KK*DATA_WIDTH-1:0]       pix_ch;
  logic [KK*WEIGHT_WIDTH-1:0]     wt_ch;

  assign window_ready = (state == IDLE);
  assign cfg_ready    = (state == IDLE);
  assign last_ch      = (ch_q == CW'(CHANNELS - 1));
  assign wt_ok        = int'(cfg_wt_addr) < ELEMS;

  always_comb begin
    pix_ch = win_q[idx(int'(ch_q), 0, 0, KERNEL_SIZE)*DATA_WIDTH
                   +: KK*DATA_WIDTH];
    wt_ch  = '0;
    for (int m = 0; m < KERNEL_SIZE; m++) begin
      for (int n = 0; n < KERNEL_SIZE; n++) begin
        wt_ch[(m*KERNEL_SIZE+n)*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
          wt_q[idx(int'(ch_q), m, n, KERNEL_SIZE)];
      end
    end
  end

  conv_dot_kxk #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .KK          (KK),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_dot (
    .pix(pix_ch),
    .wts(wt_ch),
    .sum(dot)
  );

  assign acc_nx = acc_q + dot;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (window_valid) state_nx = MAC;
      MAC:     if (last_ch)      state_nx = OUT;
      OUT:     if (out_ready)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // A weight write landing on the accepting edge is parked so the
  // in-flight window keeps the old weights.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q     <= '0;
      bias_q    <= '0;
      acc_q     <= '0;
      ch_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      for (int i = 0; i < ELEMS; i++) wt_q[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_bias_wr_en) bias_q <= cfg_bias_data;
          if (cfg_wt_wr_en && wt_ok) begin
            if (window_valid) begin
              pend_v    <= 1'b1;
              pend_addr <= cfg_wt_addr[AIW-1:0];
              pend_data <= cfg_wt_data;
            end else begin
              wt_q[cfg_wt_addr[AIW-1:0]] <= cfg_wt_data;
            end
          end
          if (window_valid) begin
            win_q <= window_data;
            acc_q <= ACC_WIDTH'(bias_q);
            ch_q  <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_nx;
          ch_q  <= ch_q + CW'(1);
          if (last_ch) begin
            out_valid <= 1'b1;
            out_data  <= DATA_WIDTH'(saturate(
                           64'(acc_nx >>> OUT_SHIFT),
                           DATA_WIDTH, RELU));
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pend_v) begin
              wt_q[pend_addr] <= pend_data;
              pend_v          <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
